// File: rtl/two_way_stream_demux_if.sv
// Stream bundle for two_way_stream_demux: one input stream, two output streams, occupancy.
// DEMUX_STATS_EN adds the statistics counter signals.
interface two_way_stream_demux_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2,
  parameter int CWIDTH = 16
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_sel;
  logic [DWIDTH-1:0] in_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [DWIDTH-1:0] out1_data;
  logic              out2_valid;
  logic              out2_ready;
  logic [DWIDTH-1:0] out2_data;
  logic [CNTW-1:0]   out1_count;
  logic [CNTW-1:0]   out2_count;
`ifdef DEMUX_STATS_EN
  logic [CWIDTH-1:0] stat1_xfers;
  logic [CWIDTH-1:0] stat2_xfers;
  logic [CWIDTH-1:0] stat_stall_cycles;

  modport master (
    output in_valid, in_sel, in_data, out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data, out2_valid, out2_data,
    input  out1_count, out2_count, stat1_xfers, stat2_xfers, stat_stall_cycles
  );
  modport slave (
    input  in_valid, in_sel, in_data, out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data, out2_valid, out2_data,
    output out1_count, out2_count, stat1_xfers, stat2_xfers, stat_stall_cycles
  );
`else
  modport master (
    output in_valid, in_sel, in_data, out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data, out2_valid, out2_data,
    input  out1_count, out2_count
  );
  modport slave (
    input  in_valid, in_sel, in_data, out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data, out2_valid, out2_data,
    output out1_count, out2_count
  );
`endif
endinterface

// File: rtl/two_way_stream_demux.sv
// Registered 1-to-2 stream router with a private FIFO per output.
// Define DEMUX_STATS_EN to add pop/stall statistics counters.
module two_way_stream_demux #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2,
  parameter int CWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  two_way_stream_demux_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_full;
  logic [1:0]        w_out_ready;
  logic [CNTW-1:0]   w_count [2];
  logic [DWIDTH-1:0] w_head  [2];

  assign w_out_ready = {bus.out2_ready, bus.out1_ready};

  // Only the addressed FIFO's fullness gates acceptance, so a stalled consumer never blocks the other path.
  assign bus.in_ready = !w_full[bus.in_sel];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DWIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]     r_wr_ptr;
      logic [PW-1:0]     r_rd_ptr;
      logic [CNTW-1:0]   r_count;

      assign w_full[gi] = (r_count == CNTW'(DEPTH));
      assign w_push[gi] = bus.in_valid && !w_full[gi] && (bus.in_sel == 1'(gi));
      assign w_pop[gi]  = (r_count != '0) && w_out_ready[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end

      // Storage needs no reset: the head is forced to zero whenever the FIFO is empty.
      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wr_ptr] <= bus.in_data;
      end

      assign w_count[gi] = r_count;
      assign w_head[gi]  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    end
  endgenerate

  assign bus.out1_valid = (w_count[0] != '0);
  assign bus.out2_valid = (w_count[1] != '0);
  assign bus.out1_data  = w_head[0];
  assign bus.out2_data  = w_head[1];
  assign bus.out1_count = w_count[0];
  assign bus.out2_count = w_count[1];

`ifdef DEMUX_STATS_EN
  logic [CWIDTH-1:0] r_stat1_xfers;
  logic [CWIDTH-1:0] r_stat2_xfers;
  logic [CWIDTH-1:0] r_stat_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat1_xfers       <= '0;
      r_stat2_xfers       <= '0;
      r_stat_stall_cycles <= '0;
    end else begin
      if (w_pop[0]) r_stat1_xfers <= r_stat1_xfers + 1'b1;
      if (w_pop[1]) r_stat2_xfers <= r_stat2_xfers + 1'b1;
      if (bus.in_valid && !bus.in_ready) r_stat_stall_cycles <= r_stat_stall_cycles + 1'b1;
    end
  end

  assign bus.stat1_xfers       = r_stat1_xfers;
  assign bus.stat2_xfers       = r_stat2_xfers;
  assign bus.stat_stall_cycles = r_stat_stall_cycles;
`endif
endmodule

// File: tb/tb_two_way_stream_demux.sv
// Directed bench for two_way_stream_demux with per-output scoreboards.
// Build with DEMUX_STATS_EN defined to also check the statistics counters.
module tb_two_way_stream_demux;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 2;
  localparam int CWIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_pop1   = 0;
  int   m_pop2   = 0;
  int   m_stall  = 0;
  logic [DWIDTH-1:0] q1 [$];
  logic [DWIDTH-1:0] q2 [$];

  always #5 clk = ~clk;

  two_way_stream_demux_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .CWIDTH(CWIDTH)) bus ();

  two_way_stream_demux #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .CWIDTH(CWIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record handshakes just before the rising edge, then advance one cycle.
  task automatic tick();
    logic [DWIDTH-1:0] e;
    @(negedge clk);
    if (reset) begin
      m_pop1 = 0; m_pop2 = 0; m_stall = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_sel) q2.push_back(bus.in_data);
        else            q1.push_back(bus.in_data);
      end
      if (bus.in_valid && !bus.in_ready) m_stall++;
      if (bus.out1_valid && bus.out1_ready) begin
        m_pop1++;
        chk("sb1_has_entry", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("sb1_data", 64'(bus.out1_data), 64'(e));
          $display("pop1 data=%08h exp=%08h", bus.out1_data, e);
        end
      end
      if (bus.out2_valid && bus.out2_ready) begin
        m_pop2++;
        chk("sb2_has_entry", 64'(q2.size() != 0), 64'd1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("sb2_data", 64'(bus.out2_data), 64'(e));
          $display("pop2 data=%08h exp=%08h", bus.out2_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [DWIDTH-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out1_count == 0 && bus.out2_count == 0) break;
      tick();
    end
    chk("drain_count1", 64'(bus.out1_count), 64'd0);
    chk("drain_count2", 64'(bus.out2_count), 64'd0);
    chk("drain_sb1_empty", 64'(q1.size()), 64'd0);
    chk("drain_sb2_empty", 64'(q2.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b0;
    bus.in_data = 32'h1234_5678;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;

    // Reset held two cycles with in_valid high
    tick(); tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("rst_out2_valid", 64'(bus.out2_valid), 64'd0);
    chk("rst_count1", 64'(bus.out1_count), 64'd0);
    chk("rst_count2", 64'(bus.out2_count), 64'd0);
    chk("rst_data1", 64'(bus.out1_data), 64'd0);
    chk("rst_data2", 64'(bus.out2_data), 64'd0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    q1.delete(); q2.delete();

    // Steering with both consumers ready
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    push(1'b0, 32'hdead_beaf);
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 32'h0000_0000;
    #1;
    chk("steer_out1_valid", 64'(bus.out1_valid), 64'd1);
    chk("steer_out1_data", 64'(bus.out1_data), 64'hdead_beaf);
    chk("steer_out2_idle", 64'(bus.out2_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("steer_out1_one_cycle", 64'(bus.out1_valid), 64'd0);
    chk("steer_out2_valid", 64'(bus.out2_valid), 64'd1);
    chk("steer_out2_data", 64'(bus.out2_data), 64'd0);
    tick();
    chk("steer_out2_one_cycle", 64'(bus.out2_valid), 64'd0);

    // Full / backpressure on output_1
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    push(1'b0, 32'h1111_0001);
    push(1'b0, 32'h1111_0002);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h1111_0003;
    #1;
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count1", 64'(bus.out1_count), 64'd2);
    tick();
    chk("full_still_blocked", 64'(bus.in_ready), 64'd0);
    bus.in_sel = 1'b1; bus.in_data = 32'h2222_0001;
    #1;
    chk("other_path_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("other_path_count2", 64'(bus.out2_count), 64'd1);
    chk("full_count1_hold", 64'(bus.out1_count), 64'd2);
    drain();

    // Simultaneous push/pop on FIFO1 across wrap-around
    bus.out1_ready = 1'b0;
    push(1'b0, 32'd100);
    bus.out1_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'(100 + i);
      #1;
      chk("pushpop_count1", 64'(bus.out1_count), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pushpop_count1_end", 64'(bus.out1_count), 64'd1);
    drain();

    // Mid-operation reset with both FIFOs full
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    push(1'b0, 32'haaaa_0001); push(1'b0, 32'haaaa_0002);
    push(1'b1, 32'hbbbb_0001); push(1'b1, 32'hbbbb_0002);
    chk("prefill_count1", 64'(bus.out1_count), 64'd2);
    chk("prefill_count2", 64'(bus.out2_count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q1.delete(); q2.delete();
    chk("midrst_out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("midrst_out2_valid", 64'(bus.out2_valid), 64'd0);
    chk("midrst_count1", 64'(bus.out1_count), 64'd0);
    chk("midrst_count2", 64'(bus.out2_count), 64'd0);
    chk("midrst_data1", 64'(bus.out1_data), 64'd0);
    push(1'b1, 32'h5555_aaaa);
    chk("post_rst_data2", 64'(bus.out2_data), 64'h5555_aaaa);
    chk("post_rst_count2", 64'(bus.out2_count), 64'd1);
    chk("post_rst_out1_empty", 64'(bus.out1_valid), 64'd0);
    drain();

`ifdef DEMUX_STATS_EN
    reset = 1'b1; tick(); reset = 1'b0;
    q1.delete(); q2.delete();
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    push(1'b0, 32'hc000_0001); push(1'b0, 32'hc000_0002);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'hc000_0003;
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid = 1'b0;
    bus.out1_ready = 1'b1;
    tick(); tick();
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 32'(32'hc100_0000 + i));
    for (int i = 0; i < 3; i++) push(1'b1, 32'(32'hc200_0000 + i));
    drain();
    chk("stat1_xfers", 64'(bus.stat1_xfers), 64'd5);
    chk("stat2_xfers", 64'(bus.stat2_xfers), 64'd3);
    chk("stat_stall", 64'(bus.stat_stall_cycles), 64'd4);
    chk("stat1_model", 64'(bus.stat1_xfers), 64'(m_pop1 % 16));
    chk("stat_stall_model", 64'(bus.stat_stall_cycles), 64'(m_stall % 16));

    reset = 1'b1; tick(); reset = 1'b0;
    q1.delete(); q2.delete();
    chk("stat_rst", 64'(bus.stat1_xfers), 64'd0);
    bus.out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(1'b0, 32'(32'hd000_0000 + i));
    drain();
    chk("stat1_wrap", 64'(bus.stat1_xfers), 64'd1);
    chk("stat1_wrap_model", 64'(bus.stat1_xfers), 64'(m_pop1 % 16));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
